gcd_stein: RTL and testbench

Parametrised, signed-capable greatest-common-divisor engine that succeeds the subtractive GCD unit. It uses the binary (Stein) algorithm: shifts and subtracts only, with no divider, and a worst-case latency linear in NBits. It has an explicit start/busy/rdy handshake and correct handling of zero and most-negative operands. It sits on the same arithmetic datapath as its predecessor and is driven by the same testbench-style `start`/`rdy` control.

---
 rtl/gcd_stein.sv | 142 ++++++++++++++
 tb/tb_gcd_stein.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gcd_stein.sv
// Binary (Stein) GCD engine: shift/subtract only, start/busy/rdy handshake,
// magnitude of two's-complement operands taken when SIGNED=1.
module gcd_stein #(
  parameter int NBits  = 16,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NBits-1:0] xi,
  input  logic [NBits-1:0] yi,
  output logic [NBits-1:0] xo,
  output logic             rdy,
  output logic             busy
);

  localparam int KW = $clog2(NBits + 1);
  localparam logic [NBits-1:0] ZERO = {NBits{1'b0}};
  localparam logic [NBits-1:0] ONE  = {{(NBits-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TWOS   = 2'd1,
    STRIP  = 2'd2,
    REDUCE = 2'd3
  } state_t;

  // Most negative value maps to 2^(NBits-1), which still fits unsigned.
  function automatic logic [NBits-1:0] mag(input logic [NBits-1:0] v);
    logic [NBits-1:0] m;
    if (SIGNED && v[NBits-1]) begin
      m = (~v) + ONE;
    end else begin
      m = v;
    end
    return m;
  endfunction

  state_t           state_r, state_s;
  logic [NBits-1:0] a_r, a_s;
  logic [NBits-1:0] b_r, b_s;
  logic [KW-1:0]    k_r, k_s;
  logic [NBits-1:0] xo_r, xo_s;
  logic             rdy_r, rdy_s;
  logic             busy_r, busy_s;
  logic [NBits-1:0] xa_s, ya_s;

  assign xa_s = mag(xi);
  assign ya_s = mag(yi);

  // Next-state and next-data computation for the Stein iteration.
  always_comb begin
    state_s = state_r;
    a_s     = a_r;
    b_s     = b_r;
    k_s     = k_r;
    xo_s    = xo_r;
    rdy_s   = rdy_r;
    busy_s  = busy_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          a_s   = xa_s;
          b_s   = ya_s;
          k_s   = {KW{1'b0}};
          rdy_s = 1'b0;
          if ((xa_s == ZERO) || (ya_s == ZERO)) begin
            xo_s  = xa_s | ya_s;
            rdy_s = 1'b1;
          end else begin
            busy_s  = 1'b1;
            state_s = TWOS;
          end
        end else begin
          state_s = IDLE;
        end
      end
      TWOS: begin
        if (!a_r[0] && !b_r[0]) begin
          a_s = a_r >> 1;
          b_s = b_r >> 1;
          k_s = k_r + {{(KW-1){1'b0}}, 1'b1};
        end else begin
          state_s = STRIP;
        end
      end
      STRIP: begin
        if (!a_r[0]) begin
          a_s = a_r >> 1;
        end else begin
          state_s = REDUCE;
        end
      end
      REDUCE: begin
        // a is odd here, so b's trailing zeros never contribute to the gcd.
        if (!b_r[0]) begin
          b_s = b_r >> 1;
        end else if (b_r == a_r) begin
          xo_s    = a_r << k_r;
          rdy_s   = 1'b1;
          busy_s  = 1'b0;
          state_s = IDLE;
        end else if (a_r > b_r) begin
          a_s = b_r;
          b_s = a_r - b_r;
        end else begin
          b_s = b_r - a_r;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= ZERO;
      b_r     <= ZERO;
      k_r     <= {KW{1'b0}};
      xo_r    <= ZERO;
      rdy_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      a_r     <= a_s;
      b_r     <= b_s;
      k_r     <= k_s;
      xo_r    <= xo_s;
      rdy_r   <= rdy_s;
      busy_r  <= busy_s;
    end
  end

  assign xo   = xo_r;
  assign rdy  = rdy_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_gcd_stein.sv
// Bench for gcd_stein: directed cases on a 16-bit signed instance plus
// randomized regression on six width/signedness configurations.
module tb_gcd_stein;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  function automatic longint gcd_ref(input longint a, input longint b);
    longint t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic longint mag_ref(input longint v, input int nb, input int sg);
    if (sg != 0 && v >= (longint'(1) << (nb - 1))) return (longint'(1) << nb) - v;
    return v;
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- directed instance: NBits=16, SIGNED=1 ----------------
  logic        d_rst, d_start, d_rdy, d_busy;
  logic [15:0] d_xi, d_yi, d_xo;

  gcd_stein #(.NBits(16), .SIGNED(1'b1)) dut (
    .clk(clk), .rst(d_rst), .start(d_start), .xi(d_xi), .yi(d_yi),
    .xo(d_xo), .rdy(d_rdy), .busy(d_busy)
  );

  task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                        output int lat, output bit busy_all, output bit busy_any);
    d_xi = x;
    d_yi = y;
    d_start = 1'b1;
    @(posedge clk); #1;
    d_start = 1'b0;
    lat = 1;
    busy_all = 1'b1;
    busy_any = d_busy;
    while (!d_rdy && lat < 200) begin
      busy_all &= d_busy;
      busy_any |= d_busy;
      @(posedge clk); #1;
      lat++;
    end
    busy_any |= d_busy;
    check("op_done", longint'(d_rdy), 1);
  endtask

  initial begin
    int lat;
    bit ba, bany;
    d_rst = 1'b1; d_start = 1'b0; d_xi = 16'd0; d_yi = 16'd0;

    check("pin_gcd", gcd_ref(48, 36), 12);
    check("pin_gcd0", gcd_ref(0, 9), 9);
    check("pin_mag", mag_ref(64'hFFF4, 16, 1), 12);
    check("pin_mag_min", mag_ref(64'h8000, 16, 1), 32768);

    repeat (2) @(posedge clk); #1;
    check("reset_xo", longint'(d_xo), 0);
    check("reset_rdy", longint'(d_rdy), 0);
    check("reset_busy", longint'(d_busy), 0);
    d_rst = 1'b0;

    run_op(16'd12, 16'd18, lat, ba, bany);
    check("g12_18_lat", lat, 8);
    check("g12_18_xo", longint'(d_xo), 6);
    check("g12_18_busy", longint'(ba), 1);
    check("g12_18_busy_low", longint'(d_busy), 0);
    repeat (6) @(posedge clk); #1;
    check("hold_xo", longint'(d_xo), 6);
    check("hold_rdy", longint'(d_rdy), 1);

    run_op(16'hFFF4, 16'd18, lat, ba, bany);
    check("neg12_lat", lat, 8);
    check("neg12_xo", longint'(d_xo), 6);

    run_op(16'd7, 16'd7, lat, ba, bany);
    check("g7_7_lat", lat, 4);
    check("g7_7_xo", longint'(d_xo), 7);

    run_op(16'd0, 16'h8000, lat, ba, bany);
    check("zero_min_lat", lat, 1);
    check("zero_min_xo", longint'(d_xo), 32768);
    check("zero_min_busy", longint'(bany), 0);

    run_op(16'd0, 16'd0, lat, ba, bany);
    check("zero_zero_xo", longint'(d_xo), 0);
    check("zero_zero_lat", lat, 1);

    // A second start while busy must not restart with the new operands.
    d_xi = 16'h7FFF; d_yi = 16'd1; d_start = 1'b1;
    @(posedge clk); #1;
    d_start = 1'b0; lat = 1;
    @(posedge clk); #1;
    lat++;
    d_xi = 16'd12; d_yi = 16'd18; d_start = 1'b1;
    @(posedge clk); #1;
    lat++;
    d_start = 1'b0;
    while (!d_rdy && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ign_rdy", longint'(d_rdy), 1);
    check("ign_xo", longint'(d_xo), 1);
    check("ign_lat_ok", longint'(lat <= 68), 1);

    d_xi = 16'h7FFF; d_yi = 16'd1; d_start = 1'b1;
    @(posedge clk); #1;
    d_start = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("abort_busy_pre", longint'(d_busy), 1);
    d_rst = 1'b1;
    @(posedge clk); #1;
    d_rst = 1'b0;
    check("abort_rdy", longint'(d_rdy), 0);
    check("abort_busy", longint'(d_busy), 0);
    check("abort_xo", longint'(d_xo), 0);

    for (int c = 0; c < 90000 && done_cnt < 6; c++) @(posedge clk);
    check("regression_done", done_cnt, 6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- randomized regression instances ----------------
  for (genvar g = 0; g < 6; g++) begin : gen
    localparam int NB = (g % 3 == 0) ? 2 : ((g % 3 == 1) ? 8 : 16);
    localparam int SG = g / 3;
    localparam int NPAIRS = (NB == 2) ? 2500 : ((NB == 8) ? 1500 : 1000);

    logic          g_rst, g_start, g_rdy, g_busy;
    logic [NB-1:0] g_xi, g_yi, g_xo;
    longint        exp_xo = 0;

    gcd_stein #(.NBits(NB), .SIGNED(SG[0])) u_dut (
      .clk(clk), .rst(g_rst), .start(g_start), .xi(g_xi), .yi(g_yi),
      .xo(g_xo), .rdy(g_rdy), .busy(g_busy)
    );

    initial begin
      logic [NB-1:0] x, y;
      int lat;
      g_rst = 1'b1; g_start = 1'b0; g_xi = '0; g_yi = '0;
      repeat (2) @(posedge clk); #1;
      g_rst = 1'b0;
      for (int n = 0; n < NPAIRS; n++) begin
        x = NB'($urandom);
        y = NB'($urandom);
        if ($urandom_range(0, 15) == 0) x = '0;
        if ($urandom_range(0, 15) == 0) y = '0;
        if ($urandom_range(0, 15) == 0) x = NB'(longint'(1) << (NB - 1));
        g_xi = x; g_yi = y; g_start = 1'b1;
        @(posedge clk); #1;
        g_start = 1'b0;
        exp_xo = gcd_ref(mag_ref(longint'(x), NB, SG), mag_ref(longint'(y), NB, SG));
        lat = 1;
        while (!g_rdy && lat < 4 * NB + 20) begin
          @(posedge clk); #1;
          lat++;
        end
        check("rand_done", longint'(g_rdy), 1);
        check("rand_lat_ok", longint'(lat <= 4 * NB + 4), 1);
      end
      done_cnt++;
    end

    // Continuous output checks against the model result.
    always @(negedge clk) begin
      if (!g_rst) begin
        if (g_rdy || g_busy) check("rand_excl", longint'(g_rdy && g_busy), 0);
        if (g_rdy) check("rand_xo", longint'(g_xo), exp_xo);
      end
    end
  end

endmodule
